// File: rtl/branch_resolve_unit.sv
// Resolves RV32I branches into a registered taken/target/mispredict/illegal result, one cycle after acceptance.
// A single output stage holds its result while out_ready is low; flush drops both the held result and any request in the same cycle.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int INSTR_BYTES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            accept;
  logic            retire;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            cond;
  logic            bad_op;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = out_valid && out_ready && !flush;

  // Both adds wrap modulo 2^XLEN by construction of the operand width.
  assign seq_pc = pc + XLEN'(INSTR_BYTES);
  assign br_pc  = pc + imm;

  always_comb begin
    eq     = (rs1 == rs2);
    lt_s   = ($signed(rs1) < $signed(rs2));
    lt_u   = (rs1 < rs2);
    cond   = 1'b0;
    bad_op = 1'b0;
    case (funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: bad_op = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      mispredict  <= 1'b0;
      illegal     <= 1'b0;
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        taken      <= cond;
        target     <= cond ? br_pc : seq_pc;
        mispredict <= cond ^ pred_taken;
        illegal    <= bad_op;
      end else if (retire) begin
        out_valid <= 1'b0;
      end

      // Clear wins over a same-cycle retire; increments stop at all-ones.
      if (cnt_clr) begin
        taken_cnt   <= '0;
        mispred_cnt <= '0;
      end else if (retire) begin
        if (taken && (taken_cnt != '1))
          taken_cnt <= taken_cnt + CNT_W'(1);
        if (mispredict && (mispred_cnt != '1))
          mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 16-bit-counter instance and a 2-bit-counter instance share the stimulus.
module tb_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic [31:0] rs1, rs2, pc, imm;
  logic [2:0]  funct3;
  logic        pred_taken, flush, cnt_clr, out_ready;

  logic        in_ready, out_valid, taken, mispredict, illegal;
  logic [31:0] target;
  logic [15:0] taken_cnt, mispred_cnt;

  logic        s_in_ready, s_out_valid, s_taken, s_mispredict, s_illegal;
  logic [31:0] s_target;
  logic [1:0]  s_taken_cnt, s_mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16), .INSTR_BYTES(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target(target), .mispredict(mispredict), .illegal(illegal),
    .taken_cnt(taken_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(2), .INSTR_BYTES(4)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(s_in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .taken(s_taken),
    .target(s_target), .mispredict(s_mispredict), .illegal(s_illegal),
    .taken_cnt(s_taken_cnt), .mispred_cnt(s_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pr);
    in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pr;
  endtask

  task automatic result(input string tag, input logic t, input logic [31:0] tg,
                        input logic m, input logic il);
    chk({tag, "_vld"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_taken"}, 64'(taken), 64'(t));
    chk({tag, "_target"}, 64'(target), 64'(tg));
    chk({tag, "_mispred"}, 64'(mispredict), 64'(m));
    chk({tag, "_illegal"}, 64'(illegal), 64'(il));
  endtask

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
    funct3 = '0; pred_taken = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_target", 64'(target), 64'd0);
    chk("rst_taken_cnt", 64'(taken_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    RST_N = 1'b1; out_ready = 1'b1;

    // Signed compare with most-negative rs1, then unsigned pair on all-ones.
    drive(3'b100, 32'h8000_0000, 32'h0000_0001, 32'h100, 32'h20, 1'b0); tick();
    result("blt", 1'b1, 32'h120, 1'b1, 1'b0);
    drive(3'b111, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h40, 1'b1); tick();
    result("bgeu", 1'b1, 32'h240, 1'b0, 1'b0);
    drive(3'b110, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h40, 1'b1); tick();
    result("bltu", 1'b0, 32'h204, 1'b1, 1'b0);
    in_valid = 1'b0; tick();
    chk("idle_vld", 64'(out_valid), 64'd0);
    chk("cnt_t1", 64'(taken_cnt), 64'd2);
    chk("cnt_m1", 64'(mispred_cnt), 64'd2);

    // Stall three cycles with the next request held, then drain four BEQs.
    out_ready = 1'b0;
    drive(3'b000, 32'd5, 32'd5, 32'h300, 32'h10, 1'b1); tick();
    drive(3'b000, 32'd5, 32'd6, 32'h400, 32'h8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      result("stall", 1'b1, 32'h310, 1'b0, 1'b0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_cnt", 64'(taken_cnt), 64'd2);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    tick();
    result("beq_b", 1'b0, 32'h404, 1'b0, 1'b0);
    drive(3'b000, 32'd7, 32'd7, 32'h500, 32'hFFFF_FFF0, 1'b0); tick();
    result("beq_c", 1'b1, 32'h4F0, 1'b1, 1'b0);
    drive(3'b000, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'h4, 1'b1); tick();
    result("beq_d_wrap", 1'b0, 32'h0, 1'b1, 1'b0);
    in_valid = 1'b0; tick();
    chk("drain_vld", 64'(out_valid), 64'd0);
    chk("cnt_t2", 64'(taken_cnt), 64'd4);
    chk("cnt_m2", 64'(mispred_cnt), 64'd4);

    // Reserved funct3 with predicted-taken counts as a mispredict.
    drive(3'b011, 32'd1, 32'd1, 32'h600, 32'h100, 1'b1); tick();
    result("illegal", 1'b0, 32'h604, 1'b1, 1'b1);
    in_valid = 1'b0; tick();
    chk("ill_cnt_m", 64'(mispred_cnt), 64'd5);
    chk("ill_cnt_t", 64'(taken_cnt), 64'd4);

    // Saturation on the 2-bit instance.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_sat", 64'(s_taken_cnt), 64'd0);
    chk("clr_main", 64'(taken_cnt), 64'd0);
    for (int k = 0; k < 5; k++) begin
      drive(3'b001, 32'd1, 32'd2, 32'h700, 32'h8, 1'b1); tick();
    end
    in_valid = 1'b0; tick();
    chk("sat_taken_cnt", 64'(s_taken_cnt), 64'd3);
    chk("sat_main_cnt", 64'(taken_cnt), 64'd5);
    chk("sat_mispred_cnt", 64'(s_mispred_cnt), 64'd0);
    drive(3'b101, 32'd3, 32'd3, 32'h800, 32'h8, 1'b0); tick();
    chk("pre_clr_vld", 64'(s_out_valid), 64'd1);
    in_valid = 1'b0; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_beats_inc_t", 64'(s_taken_cnt), 64'd0);
    chk("clr_beats_inc_m", 64'(s_mispred_cnt), 64'd0);
    chk("clr_beats_inc_main", 64'(taken_cnt), 64'd0);

    // Flush kills the held result and the same-cycle request.
    drive(3'b000, 32'd9, 32'd9, 32'h900, 32'h4, 1'b0); tick();
    chk("pre_flush_vld", 64'(out_valid), 64'd1);
    drive(3'b000, 32'd9, 32'd9, 32'hA00, 32'h4, 1'b0); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", 64'(out_valid), 64'd0);
    chk("flush_cnt_t", 64'(taken_cnt), 64'd0);
    chk("flush_cnt_m", 64'(mispred_cnt), 64'd0);
    tick();
    chk("flush_no_capture", 64'(out_valid), 64'd0);

    // Reset in the middle of a stream.
    drive(3'b000, 32'd4, 32'd4, 32'hB00, 32'h10, 1'b0); tick();
    drive(3'b000, 32'd4, 32'd4, 32'hC00, 32'h10, 1'b0); tick();
    chk("mid_cnt_t", 64'(taken_cnt), 64'd1);
    RST_N = 1'b0; in_valid = 1'b0; tick();
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_taken", 64'(taken), 64'd0);
    chk("mid_rst_target", 64'(target), 64'd0);
    chk("mid_rst_mispred", 64'(mispredict), 64'd0);
    chk("mid_rst_illegal", 64'(illegal), 64'd0);
    chk("mid_rst_cnt_t", 64'(taken_cnt), 64'd0);
    chk("mid_rst_cnt_m", 64'(mispred_cnt), 64'd0);
    RST_N = 1'b1; tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
